systolic_weight_sched: RTL and testbench

Scheduler for the weight ping-pong banks of the systolic PE array. It streams weight tiles from the upstream weight buffer into the inactive bank row by row, and flips the compute pointer when the activation feeder finishes a pass. It sequences one job of `cfg_tile_num` tiles and guarantees that a bank is never overwritten while it is being computed on. It sits between the weight buffer/FIFO and the PE array `weight_LoadPtr`/`weight_CalcPtr`/`weight_valid` inputs.

---
 rtl/systolic_weight_sched.sv | 212 +++++++++++++++++++++
 tb/tb_systolic_weight_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_weight_sched.sv
// systolic_weight_sched: streams weight tiles into the idle ping-pong bank of the
// systolic PE array and flips the compute bank as each feeder pass completes.
// Optional feature macro: SYSTOLIC_SCHED_STALL_CNT_EN adds the stall_cnt output.

module systolic_weight_sched #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int WEIGHT_W   = 8,
  parameter int TILE_CNT_W = 16
) (
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic                     job_start,
  input  logic [TILE_CNT_W-1:0]    cfg_tile_num,
  output logic                     job_busy,
  output logic                     job_done,
  input  logic                     w_in_valid,
  output logic                     w_in_ready,
  input  logic [COLS*WEIGHT_W-1:0] w_in_data,
  output logic                     weight_LoadPtr,
  output logic [ROWS-1:0]          weight_row_valid,
  output logic [COLS*WEIGHT_W-1:0] weights,
  output logic                     weight_CalcPtr,
  output logic                     calc_start,
  input  logic                     calc_done
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = COLS * WEIGHT_W;
  localparam logic [RW-1:0]         LAST_ROW = RW'(ROWS - 1);
  localparam logic [TILE_CNT_W-1:0] ONE_TILE = TILE_CNT_W'(1);

  typedef enum logic { L_IDLE, L_LOAD } load_state_e;
  typedef enum logic { C_IDLE, C_RUN  } calc_state_e;

  load_state_e           load_state_q, load_state_d;
  calc_state_e           calc_state_q, calc_state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            full_q, full_d;
  logic                  load_ptr_q, load_ptr_d;
  logic                  load_ptr_dly_q;
  logic                  calc_ptr_q, calc_ptr_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic [TILE_CNT_W-1:0] tiles_loaded_q, tiles_loaded_d;
  logic [TILE_CNT_W-1:0] tiles_done_q, tiles_done_d;
  logic [TILE_CNT_W-1:0] tile_num_q, tile_num_d;
  logic [DW-1:0]         weights_q, weights_d;
  logic [ROWS-1:0]       row_valid_q, row_valid_d;
  logic                  calc_start_q, calc_start_d;
  logic [1:0]            full_set, full_clr;
  logic                  accept, handshake;
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
  logic [31:0]           stall_q, stall_d;
`endif

  // Ready only depends on registered state so it never loops back through w_in_valid.
  assign w_in_ready = (load_state_q == L_LOAD) && !full_q[load_ptr_q] &&
                      (tiles_loaded_q < tile_num_q);
  assign handshake  = w_in_valid && w_in_ready;
  assign accept     = job_start && !busy_q;

  assign job_busy         = busy_q;
  assign job_done         = done_q;
  assign weights          = weights_q;
  assign weight_row_valid = row_valid_q;
  // The load pointer is delayed one cycle so it names the bank of the strobe being presented.
  assign weight_LoadPtr   = load_ptr_dly_q;
  assign weight_CalcPtr   = calc_ptr_q;
  assign calc_start       = calc_start_q;
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
  assign stall_cnt        = stall_q;
`endif

  // Next-state logic for job control, the load FSM, the calc FSM and the bank flags.
  always_comb begin
    load_state_d   = load_state_q;
    calc_state_d   = calc_state_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    load_ptr_d     = load_ptr_q;
    calc_ptr_d     = calc_ptr_q;
    row_cnt_d      = row_cnt_q;
    tiles_loaded_d = tiles_loaded_q;
    tiles_done_d   = tiles_done_q;
    tile_num_d     = tile_num_q;
    weights_d      = weights_q;
    row_valid_d    = '0;
    calc_start_d   = 1'b0;
    full_set       = '0;
    full_clr       = '0;

    if (accept) begin
      tile_num_d     = cfg_tile_num;
      tiles_loaded_d = '0;
      tiles_done_d   = '0;
      row_cnt_d      = '0;
      if (cfg_tile_num != '0) begin
        busy_d       = 1'b1;
        load_state_d = L_LOAD;
      end else begin
        done_d       = 1'b1;
      end
    end

    unique case (load_state_q)
      L_IDLE: ;
      L_LOAD: begin
        if (handshake) begin
          weights_d              = w_in_data;
          row_valid_d[row_cnt_q] = 1'b1;
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d            = '0;
            full_set[load_ptr_q] = 1'b1;
            load_ptr_d           = !load_ptr_q;
            tiles_loaded_d       = tiles_loaded_q + ONE_TILE;
          end else begin
            row_cnt_d            = row_cnt_q + RW'(1);
          end
        end
        if (tiles_loaded_q == tile_num_q) begin
          load_state_d = L_IDLE;
        end
      end
    endcase

    // The calc FSM is evaluated last so that job completion also parks the load FSM.
    unique case (calc_state_q)
      C_IDLE: begin
        if (busy_q && full_q[calc_ptr_q]) begin
          calc_state_d = C_RUN;
          calc_start_d = 1'b1;
        end
      end
      C_RUN: begin
        if (calc_done) begin
          full_clr[calc_ptr_q] = 1'b1;
          calc_ptr_d           = !calc_ptr_q;
          tiles_done_d         = tiles_done_q + ONE_TILE;
          calc_state_d         = C_IDLE;
          if (tiles_done_q + ONE_TILE == tile_num_q) begin
            done_d       = 1'b1;
            busy_d       = 1'b0;
            load_state_d = L_IDLE;
          end
        end
      end
    endcase

    full_d = (full_q | full_set) & ~full_clr;
  end

`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
  // Count busy cycles in which compute waits for a full bank; restart per job, saturate.
  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (busy_q && (calc_state_q == C_IDLE) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end
`endif

  // State register; reset aborts any job in flight without draining.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      load_state_q   <= L_IDLE;
      calc_state_q   <= C_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      full_q         <= '0;
      load_ptr_q     <= 1'b0;
      load_ptr_dly_q <= 1'b0;
      calc_ptr_q     <= 1'b0;
      row_cnt_q      <= '0;
      tiles_loaded_q <= '0;
      tiles_done_q   <= '0;
      tile_num_q     <= '0;
      weights_q      <= '0;
      row_valid_q    <= '0;
      calc_start_q   <= 1'b0;
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
      stall_q        <= '0;
`endif
    end else begin
      load_state_q   <= load_state_d;
      calc_state_q   <= calc_state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      full_q         <= full_d;
      load_ptr_q     <= load_ptr_d;
      load_ptr_dly_q <= load_ptr_q;
      calc_ptr_q     <= calc_ptr_d;
      row_cnt_q      <= row_cnt_d;
      tiles_loaded_q <= tiles_loaded_d;
      tiles_done_q   <= tiles_done_d;
      tile_num_q     <= tile_num_d;
      weights_q      <= weights_d;
      row_valid_q    <= row_valid_d;
      calc_start_q   <= calc_start_d;
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
      stall_q        <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_systolic_weight_sched.sv
// tb_systolic_weight_sched: directed bench for systolic_weight_sched with a row-write scoreboard.
// Define SYSTOLIC_SCHED_STALL_CNT_EN for both files to also exercise stall_cnt.

module tb_systolic_weight_sched;

  localparam int ROWS       = 4;
  localparam int COLS       = 2;
  localparam int WEIGHT_W   = 8;
  localparam int TILE_CNT_W = 16;
  localparam int DW         = COLS * WEIGHT_W;

  logic                  clock = 1'b0;
  logic                  rstN;
  logic                  jobStart;
  logic [TILE_CNT_W-1:0] cfgTileNum;
  logic                  jobBusy;
  logic                  jobDone;
  logic                  wInValid;
  logic                  wInReady;
  logic [DW-1:0]         wInData;
  logic                  weightLoadPtr;
  logic [ROWS-1:0]       weightRowValid;
  logic [DW-1:0]         weights;
  logic                  weightCalcPtr;
  logic                  calcStart;
  logic                  calcDone;
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
  logic [31:0]           stallCnt;
`endif

  int checks = 0;
  int errors = 0;

  // Expected row writes: {bank, one-hot row strobe, data}, filled as each handshake is driven.
  logic [ROWS+DW:0] sbQueue[$];
  logic [ROWS+DW:0] expEntry;
  int               expRow;
  logic             expBank;

  systolic_weight_sched #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .WEIGHT_W  (WEIGHT_W),
    .TILE_CNT_W(TILE_CNT_W)
  ) dut (
    .s_clk           (clock),
    .s_rst_n         (rstN),
    .job_start       (jobStart),
    .cfg_tile_num    (cfgTileNum),
    .job_busy        (jobBusy),
    .job_done        (jobDone),
    .w_in_valid      (wInValid),
    .w_in_ready      (wInReady),
    .w_in_data       (wInData),
    .weight_LoadPtr  (weightLoadPtr),
    .weight_row_valid(weightRowValid),
    .weights         (weights),
    .weight_CalcPtr  (weightCalcPtr),
    .calc_start      (calcStart),
    .calc_done       (calcDone)
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
    ,
    .stall_cnt       (stallCnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one weight row, wait (bounded) for ready, and record the write the array should see.
  task automatic applyStimulus(input logic [DW-1:0] data);
    int              waited;
    logic [ROWS-1:0] oneHot;
    waited   = 0;
    oneHot   = '0;
    wInData  = data;
    wInValid = 1'b1;
    while (wInReady !== 1'b1 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    if (wInReady !== 1'b1) begin
      checkOutput("ready_wait", 64'(wInReady), 64'd1);
      return;
    end
    @(posedge clock);
    oneHot[expRow] = 1'b1;
    sbQueue.push_back({expBank, oneHot, data});
    if (expRow == ROWS - 1) begin
      expRow  = 0;
      expBank = ~expBank;
    end else begin
      expRow++;
    end
    @(negedge clock);
  endtask

  task automatic startJob(input logic [TILE_CNT_W-1:0] n);
    cfgTileNum = n;
    jobStart   = 1'b1;
    @(negedge clock);
    jobStart   = 1'b0;
  endtask

  task automatic pulseCalcDone();
    calcDone = 1'b1;
    @(negedge clock);
    calcDone = 1'b0;
  endtask

  // Compare every row strobe the DUT presents against the oldest expected write.
  always @(negedge clock) begin
    if (rstN === 1'b1 && weightRowValid !== '0) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_strobe", 64'(weightRowValid), 64'd0);
      end else begin
        expEntry = sbQueue.pop_front();
        checkOutput("row_write", 64'({weightLoadPtr, weightRowValid, weights}), 64'(expEntry));
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence covering the whole job lifecycle.
  initial begin
    rstN       = 1'b0;
    jobStart   = 1'b0;
    cfgTileNum = '0;
    wInValid   = 1'b0;
    wInData    = '0;
    calcDone   = 1'b0;
    expRow     = 0;
    expBank    = 1'b0;

    #2;
    checkOutput("reset_outputs",
                64'({jobBusy, jobDone, wInReady, weightLoadPtr, weightCalcPtr, calcStart,
                     weightRowValid, weights}), 64'd0);
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);

    $display("[TB] single tile, valid held high");
    startJob(16'd1);
    checkOutput("t1_busy", 64'(jobBusy), 64'd1);
    checkOutput("t1_ready", 64'(wInReady), 64'd1);
    for (int i = 0; i < ROWS; i++) applyStimulus(16'hA100 + 16'(i));
    wInValid = 1'b0;
    checkOutput("t1_calc_start_early", 64'(calcStart), 64'd0);
    @(negedge clock);
    checkOutput("t1_calc_start", 64'(calcStart), 64'd1);
    checkOutput("t1_calc_ptr_run", 64'(weightCalcPtr), 64'd0);
    pulseCalcDone();
    checkOutput("t1_job_done", 64'(jobDone), 64'd1);
    checkOutput("t1_busy_drop", 64'(jobBusy), 64'd0);
    checkOutput("t1_ptrs", 64'({weightCalcPtr, weightLoadPtr}), 64'b11);
    @(negedge clock);
    checkOutput("t1_done_pulse", 64'(jobDone), 64'd0);

    $display("[TB] three tiles, compute withheld");
    rstN    = 1'b0;
    expRow  = 0;
    expBank = 1'b0;
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);
    startJob(16'd3);
    for (int i = 0; i < 2 * ROWS; i++) applyStimulus(16'hB200 + 16'(i));
    wInData = 16'hB300;
    checkOutput("t2_ready_blocked", 64'(wInReady), 64'd0);
    repeat (3) @(negedge clock);
    checkOutput("t2_ready_still_blocked", 64'(wInReady), 64'd0);
    pulseCalcDone();
    checkOutput("t2_ready_reassert", 64'(wInReady), 64'd1);
    checkOutput("t2_calc_start_not_yet", 64'(calcStart), 64'd0);
    checkOutput("t2_calc_ptr", 64'(weightCalcPtr), 64'd1);
    applyStimulus(16'hB300);
    checkOutput("t2_calc_start_next", 64'(calcStart), 64'd1);
    for (int i = 1; i < ROWS; i++) applyStimulus(16'hB300 + 16'(i));
    wInValid = 1'b0;
    pulseCalcDone();
    checkOutput("t2_not_done_yet", 64'(jobDone), 64'd0);
    repeat (2) @(negedge clock);
    pulseCalcDone();
    checkOutput("t2_job_done", 64'(jobDone), 64'd1);
    checkOutput("t2_busy_drop", 64'(jobBusy), 64'd0);

    $display("[TB] zero-tile job");
    @(negedge clock);
    startJob(16'd0);
    checkOutput("t3_job_done", 64'(jobDone), 64'd1);
    checkOutput("t3_busy", 64'(jobBusy), 64'd0);
    checkOutput("t3_ready", 64'(wInReady), 64'd0);
    @(negedge clock);
    checkOutput("t3_done_pulse", 64'({jobDone, jobBusy}), 64'd0);

    $display("[TB] restart while busy and spurious calc_done");
    startJob(16'd2);
    checkOutput("t4_busy", 64'(jobBusy), 64'd1);
    pulseCalcDone();
    startJob(16'd5);
    checkOutput("t4_busy_kept", 64'(jobBusy), 64'd1);
    for (int i = 0; i < 2 * ROWS; i++) applyStimulus(16'hC400 + 16'(i));
    wInValid = 1'b0;
    checkOutput("t4_ready_after_two", 64'(wInReady), 64'd0);
    pulseCalcDone();
    checkOutput("t4_not_done_yet", 64'(jobDone), 64'd0);
    checkOutput("t4_no_third_tile", 64'(wInReady), 64'd0);
    repeat (2) @(negedge clock);
    pulseCalcDone();
    checkOutput("t4_job_done", 64'(jobDone), 64'd1);

    $display("[TB] reset in the middle of a load");
    @(negedge clock);
    startJob(16'd1);
    applyStimulus(16'hD500);
    applyStimulus(16'hD501);
    wInData = 16'hD502;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t5_async_reset",
                64'({jobBusy, jobDone, wInReady, weightLoadPtr, weightCalcPtr, calcStart,
                     weightRowValid, weights}), 64'd0);
    wInValid = 1'b0;
    expRow   = 0;
    expBank  = 1'b0;
    checkOutput("t5_sb_drained", 64'(sbQueue.size()), 64'd0);
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
    checkOutput("t5_stall_reset", 64'(stallCnt), 64'd0);
`endif
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    @(negedge clock);
    startJob(16'd1);
    for (int i = 0; i < ROWS; i++) applyStimulus(16'hE600 + 16'(i));
    wInValid = 1'b0;
    @(negedge clock);
    pulseCalcDone();
    checkOutput("t5_job_done", 64'(jobDone), 64'd1);

    $display("[TB] late weights, compute starved");
    @(negedge clock);
    startJob(16'd1);
    repeat (10) @(negedge clock);
    for (int i = 0; i < ROWS; i++) applyStimulus(16'hF700 + 16'(i));
    wInValid = 1'b0;
    @(negedge clock);
    checkOutput("t6_calc_start", 64'(calcStart), 64'd1);
`ifdef SYSTOLIC_SCHED_STALL_CNT_EN
    checkOutput("t6_stall_cnt", 64'(stallCnt), 64'(10 + ROWS + 1));
`endif
    pulseCalcDone();
    checkOutput("t6_job_done", 64'(jobDone), 64'd1);

    @(negedge clock);
    checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
